// File: rtl/gdiv_pkg.sv
// Shared types and constants for the unary divider and its bitstream-to-binary converters.
package gdiv_pkg;

  // Matches the divider's random-number width.
  localparam int unsigned GDIV_BWIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    ACC  = 2'd2,
    HOLD = 2'd3
  } bs2bin_state_t;

endpackage

// File: rtl/gdiv_win_cnt.sv
// BWIDTH-bit window counter with clear, enable and a programmable terminal-compare flag.
module gdiv_win_cnt #(
  parameter int unsigned BWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [BWIDTH-1:0] term,
  output logic              hit
);

  logic [BWIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == term);

endmodule

// File: rtl/gdiv_bs2bin.sv
// Counts 1s of the divider quotient bitstream over a 2^BWIDTH-bit window; valid/ready output.
// Optional warm-up discard of the first WARMUP valid bits: define GDIV_BS2BIN_WARMUP_EN.
module gdiv_bs2bin
  import gdiv_pkg::*;
#(
  parameter int unsigned BWIDTH = GDIV_BWIDTH,
  parameter int unsigned WARMUP = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_bit,
  input  logic            in_vld,
  output logic [BWIDTH:0] out_data,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic            busy
);

  if (WARMUP < 1 || WARMUP > (1 << BWIDTH)) begin : g_bad_warmup
    $error("gdiv_bs2bin: WARMUP must lie in 1..2^BWIDTH");
  end

  bs2bin_state_t     state;
  logic [BWIDTH:0]   ones_cnt;
  logic [BWIDTH:0]   ones_nxt;
  logic [BWIDTH-1:0] win_term;
  logic              win_clr;
  logic              win_en;
  logic              win_hit;
  logic              accept;

`ifdef GDIV_BS2BIN_WARMUP_EN
  localparam bs2bin_state_t   RUN_ST    = WARM;
  localparam logic [BWIDTH-1:0] WARM_TERM = BWIDTH'(WARMUP - 1);
  assign win_term = (state == WARM) ? WARM_TERM : '1;
`else
  localparam bs2bin_state_t RUN_ST = ACC;
  assign win_term = '1;
`endif

  assign accept   = (state == HOLD) && out_vld && out_rdy;
  assign ones_nxt = ones_cnt + (BWIDTH + 1)'(in_bit);
  assign win_en   = in_vld && ((state == ACC) || (state == WARM));

  // The window count wraps to zero by itself at the ACC terminal, so only
  // conversion starts and the warm-up exit need an explicit clear.
  always_comb begin
    win_clr = ((state == IDLE) && start) || accept;
`ifdef GDIV_BS2BIN_WARMUP_EN
    if ((state == WARM) && in_vld && win_hit) win_clr = 1'b1;
`endif
  end

  gdiv_win_cnt #(
    .BWIDTH(BWIDTH)
  ) u_win_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (win_clr),
    .en   (win_en),
    .term (win_term),
    .hit  (win_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ones_cnt <= '0;
      out_data <= '0;
      out_vld  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN_ST;
            ones_cnt <= '0;
            busy     <= 1'b1;
          end
        end
`ifdef GDIV_BS2BIN_WARMUP_EN
        WARM: begin
          if (in_vld && win_hit) state <= ACC;
        end
`endif
        ACC: begin
          if (in_vld) begin
            ones_cnt <= ones_nxt;
            if (win_hit) begin
              out_data <= ones_nxt;
              out_vld  <= 1'b1;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (accept) begin
            out_vld <= 1'b0;
            if (start) begin
              state    <= RUN_ST;
              ones_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
